// File: rtl/alu_ctrl_decode_stage.sv
// RV32I decode stage: turns an instruction into ALU control fields behind a
// valid/ready handshake with a two-entry skid buffer so upstream sees a registered ready.
module alu_ctrl_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Flush,
  input  logic            In_Valid,
  output logic            In_Ready,
  input  logic [31:0]     Instruction,
  output logic            Out_Valid,
  input  logic            Out_Ready,
  output logic [3:0]      ALU_Operation,
  output logic [1:0]      Src1_Sel,
  output logic            Src2_Imm,
  output logic [XLEN-1:0] Imm,
  output logic [4:0]      Rs1,
  output logic [4:0]      Rs2,
  output logic [4:0]      Rd,
  output logic            Reg_Write,
  output logic            Illegal
);

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [6:0] F7_ZERO = 7'b0000000, F7_ALT = 7'b0100000;

  typedef struct packed {
    logic [3:0]      alu_op;
    logic [1:0]      src1_sel;
    logic            src2_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state;
  entry_t main_q, skid_q, dec;
  logic   ready_q;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = Instruction[6:0];
  assign f3     = Instruction[14:12];
  assign f7     = Instruction[31:25];
  assign imm_i  = {{20{Instruction[31]}}, Instruction[31:20]};
  assign imm_s  = {{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
  assign imm_b  = {{20{Instruction[31]}}, Instruction[7], Instruction[30:25],
                   Instruction[11:8], 1'b0};
  assign imm_u  = {Instruction[31:12], 12'b0};
  assign imm_j  = {{12{Instruction[31]}}, Instruction[19:12], Instruction[20],
                   Instruction[30:21], 1'b0};
  assign imm_sh = {27'b0, Instruction[24:20]};

  always_comb begin
    dec           = '0;
    dec.alu_op    = ALU_ADD;
    dec.rs1       = Instruction[19:15];
    dec.rs2       = Instruction[24:20];
    dec.rd        = Instruction[11:7];
    case (opcode)
      OP_R, OP_I: begin
        dec.reg_write = 1'b1;
        dec.src2_imm  = (opcode == OP_I);
        dec.imm       = (opcode == OP_I) ? imm_i : '0;
        case (f3)
          3'b000:  dec.alu_op = (opcode == OP_R && f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          3'b001:  dec.alu_op = ALU_SLL;
          3'b010:  dec.alu_op = ALU_SLT;
          3'b011:  dec.alu_op = ALU_SLTU;
          3'b100:  dec.alu_op = ALU_XOR;
          3'b101:  dec.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          3'b110:  dec.alu_op = ALU_OR;
          default: dec.alu_op = ALU_AND;
        endcase
        if (opcode == OP_R) begin
          if (!(f7 == F7_ZERO || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))))
            dec.illegal = 1'b1;
        end else if (f3 == 3'b001 || f3 == 3'b101) begin
          // Immediate shifts carry the shift amount only; funct7 must be a valid shift kind.
          dec.imm = imm_sh;
          if (f7 != F7_ZERO && !(f3 == 3'b101 && f7 == F7_ALT))
            dec.illegal = 1'b1;
        end
      end
      OP_LOAD: begin
        dec.src2_imm  = 1'b1;
        dec.imm       = imm_i;
        dec.reg_write = 1'b1;
      end
      OP_STORE: begin
        dec.src2_imm  = 1'b1;
        dec.imm       = imm_s;
      end
      OP_BRANCH: begin
        dec.imm = imm_b;
        case (f3)
          3'b000, 3'b001: dec.alu_op = ALU_SUB;
          3'b100, 3'b101: dec.alu_op = ALU_SLT;
          3'b110, 3'b111: dec.alu_op = ALU_SLTU;
          default:        dec.illegal = 1'b1;
        endcase
      end
      OP_LUI, OP_AUIPC: begin
        dec.src1_sel  = (opcode == OP_LUI) ? 2'd2 : 2'd1;
        dec.src2_imm  = 1'b1;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      OP_JAL: begin
        dec.src1_sel  = 2'd1;
        dec.src2_imm  = 1'b1;
        dec.imm       = imm_j;
        dec.reg_write = 1'b1;
      end
      OP_JALR: begin
        dec.src2_imm  = 1'b1;
        dec.imm       = imm_i;
        dec.reg_write = 1'b1;
        if (f3 != 3'b000) dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec.alu_op    = ALU_ADD;
      dec.reg_write = 1'b0;
    end
  end

  logic accept, drain;
  assign accept = In_Valid && ready_q;
  assign drain  = (state != EMPTY) && Out_Ready;

  // Ready is updated alongside the state so it always equals (state != FULL).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else if (Flush) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_q <= dec;
          state  <= ONE;
        end
        ONE: begin
          if (accept && drain) begin
            main_q <= dec;
          end else if (accept) begin
            skid_q  <= dec;
            state   <= FULL;
            ready_q <= 1'b0;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        default: if (drain) begin
          main_q  <= skid_q;
          state   <= ONE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign In_Ready      = ready_q;
  assign Out_Valid     = (state != EMPTY);
  assign ALU_Operation = main_q.alu_op;
  assign Src1_Sel      = main_q.src1_sel;
  assign Src2_Imm      = main_q.src2_imm;
  assign Imm           = main_q.imm;
  assign Rs1           = main_q.rs1;
  assign Rs2           = main_q.rs2;
  assign Rd            = main_q.rd;
  assign Reg_Write     = main_q.reg_write;
  assign Illegal       = main_q.illegal;

endmodule
